// File: rtl/atomik_uart_pkg.sv
// Shared UART framing definitions used by the transmit framer and receive deframer.
package atomik_uart_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] FS_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] FS_SYNC    = 3'd1;
  localparam logic [STATE_W-1:0] FS_TAG     = 3'd2;
  localparam logic [STATE_W-1:0] FS_PAYLOAD = 3'd3;
  localparam logic [STATE_W-1:0] FS_CSUM    = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = FS_IDLE,
    ST_SYNC    = FS_SYNC,
    ST_TAG     = FS_TAG,
    ST_PAYLOAD = FS_PAYLOAD,
    ST_CSUM    = FS_CSUM
  } framer_state_t;

endpackage

// File: rtl/uart_tx_framer.sv
// Serialises one tagged result word into SYNC, TAG, payload (LSB byte first), XOR checksum.
module uart_tx_framer
  import atomik_uart_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 8,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic [7:0]              in_tag,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam int unsigned IW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int unsigned SW = (DW > 8) ? $clog2(DW) : 3;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BYTES - 1);

  framer_state_t state, state_n;
  logic [IW-1:0] idx, idx_n, idx_inc, sel;
  logic [7:0]    csum, csum_n;
  logic [7:0]    data_n, pay_byte;
  logic          valid_n, done_n, ready_n, busy_n, load;
  logic [DW-1:0] hold_data;
  logic [7:0]    hold_tag;
  logic          accept, xfer;

  assign accept = in_valid && in_ready;
  assign xfer   = tx_valid && tx_ready;

  // Next payload byte: byte 0 when leaving TAG, otherwise the byte after idx (clamped).
  always_comb begin
    idx_inc  = (idx == LAST_IDX) ? idx : idx + IW'(1);
    sel      = (state == ST_PAYLOAD) ? idx_inc : '0;
    pay_byte = hold_data[SW'({sel, 3'b000}) +: 8];
  end

  // Next-state, byte sequencing and checksum accumulation.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    csum_n  = csum;
    data_n  = tx_data;
    valid_n = tx_valid;
    done_n  = 1'b0;
    load    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          load    = 1'b1;
          state_n = ST_SYNC;
          idx_n   = '0;
          csum_n  = '0;
          data_n  = SYNC_BYTE;
          valid_n = 1'b1;
        end
      end
      ST_SYNC: begin
        if (xfer) begin
          state_n = ST_TAG;
          data_n  = hold_tag;
        end
      end
      ST_TAG: begin
        if (xfer) begin
          state_n = ST_PAYLOAD;
          csum_n  = csum ^ tx_data;
          data_n  = pay_byte;
        end
      end
      ST_PAYLOAD: begin
        if (xfer) begin
          csum_n = csum ^ tx_data;
          if (idx == LAST_IDX) begin
            state_n = ST_CSUM;
            data_n  = csum ^ tx_data;
          end else begin
            idx_n  = idx_inc;
            data_n = pay_byte;
          end
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          state_n = ST_IDLE;
          valid_n = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        valid_n = 1'b0;
      end
    endcase
    ready_n = (state_n == ST_IDLE);
    busy_n  = (state_n != ST_IDLE);
  end

  // State, output and sequencing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      csum       <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      frame_done <= 1'b0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      csum       <= csum_n;
      tx_data    <= data_n;
      tx_valid   <= valid_n;
      frame_done <= done_n;
      in_ready   <= ready_n;
      busy       <= busy_n;
    end
  end

  // Hold register captures the word and tag on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_tag  <= '0;
    end else if (load) begin
      hold_data <= in_data;
      hold_tag  <= in_tag;
    end
  end

endmodule
